// File: rtl/rdclk_div_bank_pkg.sv
// ---------------------------------------------------------------------------
// rdclk_pkg
//   Shared definitions for the rdclk divider bank.
//   - ch_w()   : width of a channel index (at least 1 bit)
//   - div_t    : half-period divide value at the default width
//   - DIV_STOP : divide value that stops a channel
// ---------------------------------------------------------------------------
package rdclk_pkg;

  localparam int DIV_W_DFLT = 8;

  typedef logic [DIV_W_DFLT-1:0] div_t;

  localparam div_t DIV_STOP = '0;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdclk_div_bank_if.sv
// ---------------------------------------------------------------------------
// rdclk_div_bank_if
//   Configuration port of the rdclk divider bank (valid/ready).
//   cfg_valid : request present
//   cfg_ready : request accepted when cfg_valid && cfg_ready
//   cfg_ch    : target channel
//   cfg_div   : new half-period (0 stops the channel)
//   master drives requests, slave (the bank) answers with cfg_ready.
// ---------------------------------------------------------------------------
interface rdclk_div_bank_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);

  localparam int CH_W = rdclk_pkg::ch_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/rdclk_div_chan.sv
// ---------------------------------------------------------------------------
// rdclk_div_chan
//   One divided read-clock channel: half-period counter, active divide value,
//   one-deep pending divide slot, registered rdclk and rise strobe.
//
//   clk, rst_n      : fabric clock, asynchronous active-low reset
//   ch_en_i         : run enable (level)
//   sync_i          : force rdclk low / cnt to 0 and apply any pending divide
//   cfg_we_i        : accept cfg_div_i into the pending slot
//   cfg_div_i       : new half-period
//   pend_vld_o      : pending slot occupied
//   rdclk_o         : divided clock, 50% duty, straight from a flop
//   rdclk_rise_o    : high in the cycle rdclk_o goes 0->1
// ---------------------------------------------------------------------------
module rdclk_div_chan
  import rdclk_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_en_i,
  input  logic             sync_i,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  output logic             pend_vld_o,
  output logic             rdclk_o,
  output logic             rdclk_rise_o
);

  localparam logic [DIV_W-1:0] STOP    = DIV_W'(DIV_STOP);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             rdclk_q, rdclk_d;
  logic             rise_q, rise_d;

  logic             counting;
  logic             at_end;
  logic             fall;
  logic             apply;
  logic [DIV_W:0]   cnt_inc;

  always_comb begin
    // A high phase always runs to completion, even after ch_en drops.
    counting = (div_act_q != STOP) && (ch_en_i || rdclk_q);
    cnt_inc  = {1'b0, cnt_q} + (DIV_W+1)'(1);
    at_end   = counting && (cnt_inc == {1'b0, div_act_q});
    fall     = at_end && rdclk_q;
    // New divide only lands at a phase boundary where cnt restarts from 0,
    // so it can never shorten a high phase or leave cnt beyond the new D.
    apply    = pend_vld_q && (fall || !counting || sync_i);

    cnt_d      = cnt_q;
    rdclk_d    = rdclk_q;
    rise_d     = 1'b0;
    div_act_d  = div_act_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;

    if (sync_i || !counting) begin
      cnt_d   = '0;
      rdclk_d = 1'b0;
    end else if (at_end) begin
      cnt_d   = '0;
      rdclk_d = ~rdclk_q;
      rise_d  = ~rdclk_q;
    end else begin
      cnt_d   = cnt_inc[DIV_W-1:0];
    end

    if (apply) begin
      div_act_d  = pend_div_q;
      pend_vld_d = 1'b0;
    end

    // Writes only happen while the slot is empty, so they never race apply.
    if (cfg_we_i) begin
      pend_div_d = cfg_div_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_act_q  <= RST_DIV;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      rdclk_q    <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      rdclk_q    <= rdclk_d;
      rise_q     <= rise_d;
    end
  end

  assign pend_vld_o   = pend_vld_q;
  assign rdclk_o      = rdclk_q;
  assign rdclk_rise_o = rise_q;

endmodule

// File: rtl/rdclk_div_bank.sv
// ---------------------------------------------------------------------------
// rdclk_div_bank
//   Bank of NUM_CH programmable read-clock generators on one fabric clock.
//   Each channel produces a registered 50%-duty rdclk and a clk-domain rise
//   strobe; divide values are reprogrammed glitch-free through cfg.
//
//   clk, rst_n      : fabric clock, asynchronous active-low reset
//   cfg             : valid/ready config port (rdclk_div_bank_if.slave)
//   ch_en_i         : per-channel run enable
//   sync_req_i      : (RDCLK_SYNC_EN only) realign all channels
//   rdclk_o         : divided clocks
//   rdclk_rise_o    : per-channel rise strobes
//
//   Build option: define RDCLK_SYNC_EN to add sync_req_i. Without it the
//   channels free-run and are mutually unaligned.
// ---------------------------------------------------------------------------
module rdclk_div_bank
  import rdclk_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  rdclk_div_bank_if.slave   cfg,
  input  logic [NUM_CH-1:0] ch_en_i,
`ifdef RDCLK_SYNC_EN
  input  logic              sync_req_i,
`endif
  output logic [NUM_CH-1:0] rdclk_o,
  output logic [NUM_CH-1:0] rdclk_rise_o
);

  localparam int CH_W     = ch_w(NUM_CH);
  localparam int CH_SLOTS = 1 << CH_W;

  logic [NUM_CH-1:0]   pend_vld;
  logic [CH_SLOTS-1:0] pend_vld_ext;
  logic                cfg_ready;
  logic                cfg_hs;
  logic                sync;

  // Unused channel codes read as "never pending": requests to them are
  // accepted and dropped.
  always_comb begin
    pend_vld_ext               = '0;
    pend_vld_ext[NUM_CH-1:0]   = pend_vld;
  end

  assign cfg_ready     = ~pend_vld_ext[cfg.cfg_ch];
  assign cfg.cfg_ready = cfg_ready;
  assign cfg_hs        = cfg.cfg_valid & cfg_ready;

`ifdef RDCLK_SYNC_EN
  assign sync = sync_req_i;
`else
  assign sync = 1'b0;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rdclk_div_chan #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_en_i      (ch_en_i[ch]),
      .sync_i       (sync),
      .cfg_we_i     (cfg_hs && (cfg.cfg_ch == CH_W'(ch))),
      .cfg_div_i    (cfg.cfg_div),
      .pend_vld_o   (pend_vld[ch]),
      .rdclk_o      (rdclk_o[ch]),
      .rdclk_rise_o (rdclk_rise_o[ch])
    );
  end

endmodule

// File: tb/tb_rdclk_div_bank.sv
// ---------------------------------------------------------------------------
// tb_rdclk_div_bank
//   Self-checking bench for rdclk_div_bank (NUM_CH=2, DIV_W=8, RESET_DIV=2).
//   Expected per-cycle rdclk / rdclk_rise values are pushed into a queue as
//   stimulus is applied and popped when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_rdclk_div_bank;

  typedef struct packed {
    logic [1:0] clk;
    logic [1:0] rise;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ch_en = 2'b00;
  logic [1:0] rdclk_o;
  logic [1:0] rdclk_rise_o;
`ifdef RDCLK_SYNC_EN
  logic       sync_req = 1'b0;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  rdclk_div_bank_if #(.NUM_CH(2), .DIV_W(8)) cfg_if ();

  rdclk_div_bank #(
    .NUM_CH    (2),
    .DIV_W     (8),
    .RESET_DIV (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_if),
    .ch_en_i      (ch_en),
`ifdef RDCLK_SYNC_EN
    .sync_req_i   (sync_req),
`endif
    .rdclk_o      (rdclk_o),
    .rdclk_rise_o (rdclk_rise_o)
  );

  always #5 clk = ~clk;

  // Ideal waveform m clk cycles after a low-phase start with half-period d:
  // bit0 = rdclk, bit1 = rise strobe.
  function automatic logic [1:0] ew(input int m, input int d);
    logic c, r;
    c = ((m / d) % 2) == 1;
    r = (m > 0) && ((m % d) == 0) && c;
    return {r, c};
  endfunction

  function automatic exp_t mk(input logic [1:0] w0, input logic [1:0] w1);
    exp_t e;
    e.clk  = {w1[0], w0[0]};
    e.rise = {w1[1], w0[1]};
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    ch_en            = 2'b00;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 1'b0;
    cfg_if.cfg_div   = 8'd0;
`ifdef RDCLK_SYNC_EN
    sync_req         = 1'b0;
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    ch_en            = 2'b00;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 1'b0;
    cfg_if.cfg_div   = 8'd0;
    step();
    n_assert++;
    if (rdclk_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_rdclk got %b expected 00", rdclk_o);
    end
    n_assert++;
    if (rdclk_rise_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_rise got %b expected 00", rdclk_rise_o);
    end
    for (int c = 0; c < 2; c++) begin
      cfg_if.cfg_ch = c[0];
      #1;
      n_assert++;
      if (cfg_if.cfg_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready ch%0d got %b expected 1", c, cfg_if.cfg_ready);
      end
    end
    rst_n = 1'b1;
    step();
    step();
    n_assert++;
    if (rdclk_o !== 2'b00) begin
      n_fail++; $display("FAIL idle_rdclk got %b expected 00", rdclk_o);
    end
  endtask

  task automatic test_default_run();
    exp_t e;
    do_reset();
    ch_en = 2'b11;
    for (int n = 1; n <= 12; n++) begin
      sb_q.push_back(mk(ew(n, 2), ew(n, 2)));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL default rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL default rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
    end
  endtask

  task automatic test_cfg_mid_high();
    exp_t e;
    do_reset();
    ch_en = 2'b11;
    for (int n = 1; n <= 25; n++) begin
      sb_q.push_back(mk((n < 4) ? ew(n, 2) : ew(n - 4, 5), ew(n, 2)));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL mid_high rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL mid_high rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
      if (n == 2) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 8'd5;
        #1;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL mid_high ready_pre got %b expected 1", cfg_if.cfg_ready);
        end
      end
      if (n == 3) begin
        cfg_if.cfg_valid = 1'b0;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL mid_high ready_pending got %b expected 0", cfg_if.cfg_ready);
        end
      end
      if (n == 4) begin
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL mid_high ready_after_fall got %b expected 1", cfg_if.cfg_ready);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [1:0] w0, w1;
    do_reset();
    ch_en = 2'b11;
    for (int n = 1; n <= 26; n++) begin
      w0 = (n < 8) ? ew(n, 2) : ew(n - 8, 3);
      w1 = (n < 4) ? ew(n, 2) : (n < 10) ? ew(n - 4, 3) : ew(n - 10, 7);
      sb_q.push_back(mk(w0, w1));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL b2b rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL b2b rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
      if (n == 2) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b1; cfg_if.cfg_div = 8'd3;
      end
      if (n == 3) begin
        cfg_if.cfg_div = 8'd7;
        #1;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b stall got %b expected 0", cfg_if.cfg_ready);
        end
        cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 8'd3;
        #1;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b other_ch_ready got %b expected 1", cfg_if.cfg_ready);
        end
      end
      if (n == 4) begin
        cfg_if.cfg_ch = 1'b1; cfg_if.cfg_div = 8'd7;
        #1;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b ready_return got %b expected 1", cfg_if.cfg_ready);
        end
      end
      if (n == 5) begin
        cfg_if.cfg_valid = 1'b0;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b second_pending got %b expected 0", cfg_if.cfg_ready);
        end
      end
      if (n == 10) begin
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b second_applied got %b expected 1", cfg_if.cfg_ready);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    exp_t       e;
    logic [1:0] w0;
    do_reset();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 8'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    n_assert++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL en_drop idle_apply got %b expected 1", cfg_if.cfg_ready);
    end
    ch_en = 2'b01;
    for (int n = 1; n <= 22; n++) begin
      w0 = (n < 8) ? ew(n, 4) : (n < 14) ? 2'b00 : ew(n - 14, 4);
      sb_q.push_back(mk(w0, 2'b00));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL en_drop rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL en_drop rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
      if (n == 5)  ch_en = 2'b00;
      if (n == 14) ch_en = 2'b01;
    end
  endtask

  task automatic test_stop_d0();
    exp_t       e;
    logic [1:0] w0;
    do_reset();
    ch_en = 2'b11;
    for (int n = 1; n <= 16; n++) begin
      w0 = (n < 4) ? ew(n, 2) : (n <= 10) ? 2'b00 : ew(n - 10, 1);
      sb_q.push_back(mk(w0, ew(n, 2)));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL stop_d0 rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL stop_d0 rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
      if (n == 2) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 8'd0;
      end
      if (n == 3) cfg_if.cfg_valid = 1'b0;
      if (n == 8) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd1;
      end
      if (n == 9) begin
        cfg_if.cfg_valid = 1'b0;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL stop_d0 d1_pending got %b expected 0", cfg_if.cfg_ready);
        end
      end
      if (n == 10) begin
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL stop_d0 d1_applied got %b expected 1", cfg_if.cfg_ready);
        end
      end
    end
  endtask

`ifdef RDCLK_SYNC_EN
  task automatic test_sync();
    exp_t       e;
    logic [1:0] w0, w1;
    do_reset();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b1; cfg_if.cfg_div = 8'd3;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    ch_en = 2'b11;
    for (int n = 1; n <= 20; n++) begin
      w0 = (n < 7) ? ew(n, 2) : ew(n - 7, 2);
      w1 = (n < 7) ? ew(n, 3) : ew(n - 7, 2);
      sb_q.push_back(mk(w0, w1));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL sync rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL sync rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
      if (n == 5) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b1; cfg_if.cfg_div = 8'd2;
      end
      if (n == 6) begin
        cfg_if.cfg_valid = 1'b0;
        sync_req = 1'b1;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL sync pending got %b expected 0", cfg_if.cfg_ready);
        end
      end
      if (n == 7) begin
        sync_req = 1'b0;
        n_assert++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL sync applied got %b expected 1", cfg_if.cfg_ready);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    ch_en = 2'b11;
    for (int n = 1; n <= 3; n++) begin
      sb_q.push_back(mk(ew(n, 2), ew(n, 2)));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL async_pre rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      if (n == 2) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 8'd5;
      end
      if (n == 3) cfg_if.cfg_valid = 1'b0;
    end
    // Mid-cycle reset assertion: outputs must clear without waiting for clk.
    #3;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (rdclk_o !== 2'b00) begin
      n_fail++; $display("FAIL async rdclk got %b expected 00", rdclk_o);
    end
    n_assert++;
    if (rdclk_rise_o !== 2'b00) begin
      n_fail++; $display("FAIL async rise got %b expected 00", rdclk_rise_o);
    end
    n_assert++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL async ready got %b expected 1", cfg_if.cfg_ready);
    end
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      sb_q.push_back(mk(ew(n, 2), ew(n, 2)));
      step();
      e = sb_q.pop_front();
      n_assert++;
      if (rdclk_o !== e.clk) begin
        n_fail++; $display("FAIL async_post rdclk n=%0d got %b expected %b", n, rdclk_o, e.clk);
      end
      n_assert++;
      if (rdclk_rise_o !== e.rise) begin
        n_fail++; $display("FAIL async_post rise n=%0d got %b expected %b", n, rdclk_rise_o, e.rise);
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 1'b0;
    cfg_if.cfg_div   = 8'd0;
    test_reset();
    test_default_run();
    test_cfg_mid_high();
    test_back_to_back();
    test_en_drop();
    test_stop_d0();
`ifdef RDCLK_SYNC_EN
    test_sync();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
